// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the oversampled UART receiver.
//   - default clock / baud / oversample ratio and the in-bit sample ticks
//   - FSM state encoding (PARITY only exists when UART_RX_PARITY_EN is defined)
//   - rx_evt_t: one-cycle byte/frame event from the FSM to the output stage
//   - calc_tick_div(): rounded clock-to-oversample-tick divider
package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_BAUD_RATE   = 9600;
  localparam int DEF_OVERSAMPLE  = 16;

  // "Tick k" is the k-th oversample tick after the bit started.
  localparam int SMP_T0 = 7;
  localparam int SMP_T1 = 8;
  localparam int SMP_T2 = 9;  // majority decided here

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

  typedef struct packed {
    logic       done;     // good stop bit, byte ready
    logic       frm_err;  // stop bit sampled low
`ifdef UART_RX_PARITY_EN
    logic       par_err;  // even parity mismatch on the completed byte
`endif
    logic [7:0] data;
  } rx_evt_t;

  // round(clk / (baud * os))
  function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-clock tick at terminal count.
//   gclk   : clock
//   grst_n : async active-low reset
//   clr    : synchronous clear, realigns the tick phase to a start edge
//   tick   : high for one clock every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)         cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (cnt == TC)  cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TC) && !clr;

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled 8N1 UART receiver with a valid/ack
// holding register and framing / overrun detection.
//   Clock_100MHz  : system clock
//   Reset_n       : async active-low reset
//   TXD           : serial line from host (idle high, asynchronous)
//   RX_ack        : consumer takes RX_data while RX_valid is high
//   RX_data       : last accepted byte, stable while RX_valid is high
//   RX_valid      : byte available
//   Framing_error : 1-clock pulse, stop bit sampled low (byte discarded)
//   Overrun_error : 1-clock pulse, byte dropped since holding reg was full
//   Busy          : FSM not in IDLE
//   Parity_error  : (UART_RX_PARITY_EN only) 1-clock pulse with RX_valid on
//                   an even-parity mismatch; the byte is still delivered
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE  // only 16 is supported
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic       TXD,
  input  logic       RX_ack,
  output logic [7:0] RX_data,
  output logic       RX_valid,
  output logic       Framing_error,
  output logic       Overrun_error,
`ifdef UART_RX_PARITY_EN
  output logic       Parity_error,
`endif
  output logic       Busy
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);

  // --- line synchronizer (resets to idle-high) ---
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], TXD};
  end

  assign rxs = sync_q[1];

  // --- oversample tick, phase-aligned to the start edge ---
  logic [2:0] state;
  logic       start_edge;
  logic       tick;

  assign start_edge = (state == ST_IDLE) && !rxs;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .gclk   (Clock_100MHz),
    .grst_n (Reset_n),
    .clr    (start_edge),
    .tick   (tick)
  );

  // --- bit timing ---
  // bit_cnt counts ticks elapsed in the current bit; the tick that moves it
  // to k is "tick k", and the 16th tick (15 -> 0) closes the bit.
  logic [3:0] bit_cnt;
  logic [3:0] bit_nxt;
  logic       decide;
  logic       bit_end;
  logic [1:0] smp;
  logic       maj;

  assign bit_nxt = bit_cnt + 4'd1;
  assign decide  = tick && (bit_nxt == 4'(SMP_T2));
  assign bit_end = tick && (bit_cnt == 4'd15);
  // samples from ticks 7 and 8 plus the live value at tick 9
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

  // --- receive FSM ---
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  rx_evt_t    evt;
`ifdef UART_RX_PARITY_EN
  logic       par_bad;
`endif

  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      smp     <= 2'b11;
      shreg   <= '0;
      evt     <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      evt.done    <= 1'b0;
      evt.frm_err <= 1'b0;

      if (tick) bit_cnt <= bit_nxt;
      if (tick && (bit_nxt == 4'(SMP_T0))) smp[0] <= rxs;
      if (tick && (bit_nxt == 4'(SMP_T1))) smp[1] <= rxs;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state   <= ST_START;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (decide && maj)  state <= ST_IDLE;  // glitch, not a start bit
          else if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (decide) shreg <= {maj, shreg[7:1]};  // LSB first
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (decide)  par_bad <= maj ^ (^shreg);  // even parity
          if (bit_end) state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // decided mid-bit so the next start edge is never missed
          if (decide) begin
            if (maj) begin
              evt.done <= 1'b1;
              evt.data <= shreg;
`ifdef UART_RX_PARITY_EN
              evt.par_err <= par_bad;
`endif
              state <= ST_IDLE;
            end else begin
              evt.frm_err <= 1'b1;
              state       <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // hold off through a break until the line is seen high on a tick
          if (tick && rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // --- holding register / handshake ---
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      RX_data       <= '0;
      RX_valid      <= 1'b0;
      Overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_error  <= 1'b0;
`endif
    end else begin
      Overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Parity_error  <= 1'b0;
`endif
      if (evt.done) begin
        if (RX_valid && !RX_ack) begin
          Overrun_error <= 1'b1;  // keep the unread byte
        end else begin
          // an ack in the completion cycle frees the slot for the new byte
          RX_data  <= evt.data;
          RX_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          Parity_error <= evt.par_err;
`endif
        end
      end else if (RX_ack) begin
        RX_valid <= 1'b0;
      end
    end
  end

  assign Framing_error = evt.frm_err;
  assign Busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled. Runs the receiver with a small
// clock so one bit is 128 clocks (tick divider 8); TXD is driven with real
// delays so baud mismatch can be applied independently of the clock.
module tb_uart_rx_oversampled;

  localparam int  CLK_HZ = 1_228_800;  // 9600 * 16 * 8
  localparam int  BAUD   = 9600;
  localparam real BIT    = 1280.0;     // 128 clocks of 10 time units
  localparam real BIT_F  = BIT / 1.02; // baud +2%
  localparam real BIT_S  = BIT * 1.02; // baud -2%

  logic       clk = 1'b0;
  logic       rst_n;
  logic       txd;
  logic       ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frm_err;
  logic       ovr_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       par_err;
`endif

  uart_rx_oversampled #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .OVERSAMPLE  (16)
  ) dut (
    .Clock_100MHz  (clk),
    .Reset_n       (rst_n),
    .TXD           (txd),
    .RX_ack        (ack),
    .RX_data       (rx_data),
    .RX_valid      (rx_valid),
    .Framing_error (frm_err),
    .Overrun_error (ovr_err),
`ifdef UART_RX_PARITY_EN
    .Parity_error  (par_err),
`endif
    .Busy          (busy)
  );

  always #5 clk = ~clk;

  // event counters, sampled on the falling edge
  int   n_vld = 0, n_frm = 0, n_ovr = 0, n_par = 0;
  logic vld_q = 1'b0;

  always @(negedge clk) begin
    if (frm_err) n_frm++;
    if (ovr_err) n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (par_err) n_par++;
`endif
    if (rx_valid && !vld_q) n_vld++;
    vld_q = rx_valid;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // start + 8 data bits (+ even parity bit, optionally inverted)
  task automatic send_bits(input logic [7:0] b, input real bt, input logic par_flip);
    txd = 1'b0; #(bt);
    for (int i = 0; i < 8; i++) begin
      txd = b[i]; #(bt);
    end
`ifdef UART_RX_PARITY_EN
    txd = (^b) ^ par_flip; #(bt);
`else
    if (par_flip) $display("note: parity flip has no effect in 8N1 build");
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input real bt);
    send_bits(b, bt, 1'b0);
    txd = 1'b1; #(bt);
  endtask

  task automatic ack_pulse(input string tag);
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    chk(tag, rx_valid, 0);
  endtask

  int s_vld, s_frm, s_ovr, s_par;

  task automatic snap();
    s_vld = n_vld; s_frm = n_frm; s_ovr = n_ovr; s_par = n_par;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    txd = 1'b1; ack = 1'b0; rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data",  rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_frm",   frm_err, 0);
    chk("rst_ovr",   ovr_err, 0);
    chk("rst_busy",  busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // basic byte, then ack clears valid on the next clock
    snap();
    send_byte(8'h41, BIT); #(BIT);
    chk("b41_valid", rx_valid, 1);
    chk("b41_data",  rx_data, 'h41);
    chk("b41_nvld",  n_vld - s_vld, 1);
    chk("b41_frm",   n_frm - s_frm, 0);
    chk("b41_ovr",   n_ovr - s_ovr, 0);
    ack_pulse("b41_ack");

    // 3-tick low glitch is rejected as a start bit
    snap();
    txd = 1'b0; #240; txd = 1'b1; #160;
    chk("gl_busy_mid", busy, 1);
    #(2 * BIT);
    chk("gl_busy_end", busy, 0);
    chk("gl_nvld",     n_vld - s_vld, 0);
    chk("gl_frm",      n_frm - s_frm, 0);

    // stop bit held low for 2 bit times
    snap();
    send_bits(8'h5A, BIT, 1'b0);
    txd = 1'b0; #(BIT * 1.5);
    chk("fe_busy_low", busy, 1);
    chk("fe_frm_mid",  n_frm - s_frm, 1);
    #(BIT * 0.5);
    txd = 1'b1; #(BIT);
    chk("fe_busy_hi",  busy, 0);
    chk("fe_frm",      n_frm - s_frm, 1);
    chk("fe_nvld",     n_vld - s_vld, 0);
    send_byte(8'h33, BIT); #(BIT);
    chk("fe33_data",   rx_data, 'h33);
    chk("fe33_valid",  rx_valid, 1);
    chk("fe33_frm",    n_frm - s_frm, 1);
    ack_pulse("fe33_ack");

    // overrun: second byte dropped while first is unread
    snap();
    send_byte(8'h11, BIT); #(BIT);
    chk("ov11_data", rx_data, 'h11);
    send_byte(8'h22, BIT); #(BIT);
    chk("ov_data",   rx_data, 'h11);
    chk("ov_valid",  rx_valid, 1);
    chk("ov_cnt",    n_ovr - s_ovr, 1);
    ack_pulse("ov_ack");

    // ack in the completion cycle: new byte loads, no overrun
    snap();
    send_byte(8'h11, BIT); #(BIT);
    chk("oa11_data", rx_data, 'h11);
    fork
      send_byte(8'h22, BIT);
      begin
        int c;
        c = 0;
        while (!busy && c < 4000) begin @(negedge clk); c++; end
        while (busy && c < 4000)  begin @(negedge clk); c++; end
        ack = 1'b1;
        @(negedge clk) ack = 1'b0;
        chk("oa_window", int'(c < 4000), 1);
      end
    join
    #(BIT);
    chk("oa_data",  rx_data, 'h22);
    chk("oa_valid", rx_valid, 1);
    chk("oa_ovr",   n_ovr - s_ovr, 0);
    ack_pulse("oa_ack");

    // reset mid-DATA of 0xC3 (start + 3 data bits sent), then 0x7E
    txd = 1'b0; #(BIT);
    txd = 1'b1; #(BIT);
    txd = 1'b1; #(BIT);
    txd = 1'b0; #(BIT * 0.5);
    chk("mr_busy_pre", busy, 1);
    rst_n = 1'b0;
    #30;
    chk("mr_data",  rx_data, 0);
    chk("mr_valid", rx_valid, 0);
    chk("mr_busy",  busy, 0);
    chk("mr_frm",   frm_err, 0);
    chk("mr_ovr",   ovr_err, 0);
    txd = 1'b1; #50;
    @(negedge clk) rst_n = 1'b1;
    snap();
    #(2 * BIT);
    send_byte(8'h7E, BIT); #(BIT);
    chk("mr7e_nvld", n_vld - s_vld, 1);
    chk("mr7e_data", rx_data, 'h7E);
    chk("mr7e_frm",  n_frm - s_frm, 0);
    ack_pulse("mr7e_ack");

    // +/-2% baud mismatch
    snap();
    send_byte(8'hA5, BIT_F); #(BIT);
    chk("fast_data", rx_data, 'hA5);
    chk("fast_nvld", n_vld - s_vld, 1);
    ack_pulse("fast_ack");
    snap();
    send_byte(8'h3C, BIT_S); #(BIT);
    chk("slow_data", rx_data, 'h3C);
    chk("slow_nvld", n_vld - s_vld, 1);
    chk("slow_frm",  n_frm - s_frm, 0);
    ack_pulse("slow_ack");

`ifdef UART_RX_PARITY_EN
    snap();
    send_bits(8'h03, BIT, 1'b1);
    txd = 1'b1; #(BIT); #(BIT);
    chk("pe_data",  rx_data, 'h03);
    chk("pe_valid", rx_valid, 1);
    chk("pe_cnt",   n_par - s_par, 1);
    ack_pulse("pe_ack");
    snap();
    send_byte(8'h03, BIT); #(BIT);
    chk("pok_data", rx_data, 'h03);
    chk("pok_cnt",  n_par - s_par, 0);
    ack_pulse("pok_ack");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
